// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter.
// Bytes queue in a small FIFO; level IRQ when the queue drains.

module uart_tx_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
  parameter int          DIV       = 16,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        IRQ,
  output logic        tx
);

  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  FULL_N = 5'(DEPTH);
  localparam logic [15:0] LAST   = 16'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [15:0]   baud;
  logic          txen, irqen;
  logic          overflow, pending;
  logic          irq_q, tx_q;

  logic sel_data, sel_stat;
  logic sel_ctrl, sel_rsv;
  logic wr_data, wr_ctrl;
  logic full, empty, busy;
  logic tick, pop, push_ok;
  logic ovf_set, stop_done;

  assign sel_data = addr[3:2] == 2'd0;
  assign sel_stat = addr[3:2] == 2'd1;
  assign sel_ctrl = addr[3:2] == 2'd2;
  assign sel_rsv  = addr[3:2] == 2'd3;

  assign wr_data = we & be[0] & sel_data;
  assign wr_ctrl = we & be[0] & sel_ctrl;

  assign full  = count == FULL_N;
  assign empty = count == 5'd0;
  assign busy  = state_q != IDLE;
  assign tick  = busy && (baud == LAST);

  assign pop = (state_q == IDLE)
             & txen & ~empty;
  // a pop in the same cycle frees a slot
  assign push_ok = wr_data & (~full | pop);
  assign ovf_set = wr_data & full & ~pop;
  assign stop_done =
    (state_q == STOP) & tick;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pop)  state_d = START;
      START: if (tick) state_d = DATA;
      DATA:
        if (tick && bit_idx == 3'd7)
          state_d = STOP;
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 5'd1;
      else if (pop && !push_ok)
        count <= count - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud    <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      if (!busy || tick) baud <= '0;
      else baud <= baud + 16'd1;
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_idx <= '0;
      end else if (state_q == DATA
                   && tick) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txen     <= 1'b0;
      irqen    <= 1'b0;
      overflow <= 1'b0;
      pending  <= 1'b0;
      irq_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        txen  <= wd[0];
        irqen <= wd[1];
      end
      if (wr_ctrl)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      // clear beats a coincident set
      if (wr_ctrl || push_ok)
        pending <= 1'b0;
      else if (stop_done && empty)
        pending <= 1'b1;
      irq_q <= irqen & pending;
      unique case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift[0];
        default: tx_q <= 1'b1;
      endcase
    end
  end

  always_comb begin
    RD = '0;
    unique case (1'b1)
      sel_stat:
        RD = {22'd0, count, pending,
              overflow, empty, full, busy};
      sel_ctrl:
        RD = {30'd0, irqen, txen};
      sel_data: RD = '0;
      sel_rsv:  RD = '0;
      default:  RD = '0;
    endcase
  end

  assign IRQ = irq_q;
  assign tx  = tx_q;

  logic unused_bits;
  assign unused_bits = ^{PC, addr[31:4],
    addr[1:0], be[3:1], wd[31:8],
    BASE_ADDR};

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: scoreboard bench for uart_tx_dev.
// Frames and register probes are queued, then checked by monitors.

module tb_uart_tx_dev;

  localparam int          DIV  = 4;
  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] PC;
  logic [31:0] RD;
  logic        IRQ;
  logic        tx;

  uart_tx_dev #(
    .BASE_ADDR(BASE),
    .DIV(DIV),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .we(we),
    .be(be),
    .wd(wd),
    .PC(PC),
    .RD(RD),
    .IRQ(IRQ),
    .tx(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } probe_t;

  probe_t     pq[$];
  logic [7:0] fq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         wr_edge = 0;

  // register / pin probe monitor
  always @(negedge clk) begin
    probe_t      p;
    logic [31:0] act;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      if (p.sel == 0)      act = RD;
      else if (p.sel == 1) act = {31'd0, tx};
      else                 act = {31'd0, IRQ};
      n_cmp++;
      if (act !== p.val) begin
        n_err++;
        $display("FAIL %s: got %h, required %h",
                 p.name, act, p.val);
      end
    end
  end

  // serial frame monitor, cycle exact
  logic       rx_act = 1'b0;
  int         c;
  logic [7:0] exp_b, got_b;
  logic       unexp, bad;
  logic       lv;

  always @(negedge clk) begin
    if (reset) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        c      = 0;
        bad    = 1'b0;
        got_b  = 8'h00;
        unexp  = fq.size() == 0;
        exp_b  = unexp ? 8'h00 : fq[0];
      end
    end else begin
      c++;
      if (c < DIV)             lv = 1'b0;
      else if (c < 9 * DIV)    lv = exp_b[(c - DIV) / DIV];
      else                     lv = 1'b1;
      if (tx !== lv) bad = 1'b1;
      if (c >= DIV && c < 9 * DIV && (c % DIV) == 2)
        got_b[(c - DIV) / DIV] = tx;
      if (c == 10 * DIV - 1) begin
        n_cmp++;
        if (!unexp) void'(fq.pop_front());
        if (unexp || bad || got_b !== exp_b) begin
          n_err++;
          $display("FAIL frame: got %h (timing_err=%0d unexpected=%0d), required %h",
                   got_b, bad, unexp, exp_b);
        end
        rx_act = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] r,
                        input logic [31:0] d,
                        input logic [3:0] b);
    addr = BASE + {28'd0, r, 2'b00};
    wd   = d;
    be   = b;
    we   = 1'b1;
    PC   = 32'h0000_3000 + 32'(cyc);
    @(posedge clk);
    #1;
    we      = 1'b0;
    be      = 4'h0;
    wr_edge = cyc;
  endtask

  task automatic push_byte(input logic [7:0] v,
                           input bit accepted);
    if (accepted) fq.push_back(v);
    bus_wr(2'd0, {24'hABCDEF, v}, 4'h1);
  endtask

  task automatic probe_rd(input logic [1:0] r,
                          input logic [31:0] v,
                          input string n);
    addr = BASE + {28'd0, r, 2'b00};
    pq.push_back('{n, 0, v});
  endtask

  task automatic probe_pin(input int s,
                           input logic v,
                           input string n);
    pq.push_back('{n, s, {31'd0, v}});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1;
    we    = 1'b0;
    be    = 4'h0;
    wd    = '0;
    addr  = BASE;
    PC    = '0;
    step(3);
    reset = 1'b0;

    probe_rd(2'd1, 32'h4, "rst_status");
    probe_pin(1, 1'b1, "rst_tx");
    probe_pin(2, 1'b0, "rst_irq");
    step(1);
    probe_rd(2'd2, 32'h0, "rst_ctrl");
    step(1);

    // single byte, cycle exact start latency
    bus_wr(2'd2, 32'h1, 4'h1);
    push_byte(8'hA5, 1'b1);
    w = wr_edge;
    probe_rd(2'd1, 32'h20, "a5_queued");
    probe_pin(1, 1'b1, "a5_tx_e0");
    step(1);
    probe_rd(2'd1, 32'h05, "a5_popped");
    probe_pin(1, 1'b1, "a5_tx_e1");
    step(1);
    probe_pin(1, 1'b0, "a5_tx_e2");
    wait_to(w + 42);
    probe_rd(2'd1, 32'h14, "a5_done");
    probe_pin(2, 1'b0, "a5_irq_off");
    step(1);

    // overflow with TXEN off, then drain
    bus_wr(2'd2, 32'h0, 4'h1);
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    push_byte(8'h55, 1'b0);
    probe_rd(2'd1, 32'h8A, "ovf_status");
    step(1);
    bus_wr(2'd2, 32'h3, 4'h1);
    w = wr_edge;
    probe_rd(2'd1, 32'h82, "ovf_cleared");
    wait_to(w + 163);
    probe_rd(2'd1, 32'h05, "drain_last");
    probe_pin(2, 1'b0, "drain_irq0");
    step(1);
    probe_rd(2'd1, 32'h14, "drain_idle");
    probe_pin(2, 1'b0, "irq_lag");
    step(1);
    probe_pin(2, 1'b1, "irq_rise");
    step(1);

    // DATA push clears the interrupt
    push_byte(8'h3C, 1'b1);
    w = wr_edge;
    probe_pin(2, 1'b1, "irq_hold");
    step(1);
    probe_pin(2, 1'b0, "irq_clear");
    probe_rd(2'd1, 32'h05, "irq_status");
    wait_to(w + 45);

    // reset during data bit 3
    push_byte(8'h96, 1'b0);
    w = wr_edge;
    wait_to(w + 18);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    probe_rd(2'd1, 32'h4, "abort_status");
    probe_pin(1, 1'b1, "abort_tx");
    probe_pin(2, 1'b0, "abort_irq");
    step(1);
    for (int i = 0; i < 12; i++) begin
      probe_pin(1, 1'b1, "abort_quiet");
      step(DIV);
    end

    // push on the cycle a full FIFO pops
    push_byte(8'hA1, 1'b1);
    push_byte(8'hB2, 1'b1);
    push_byte(8'hC3, 1'b1);
    push_byte(8'hD4, 1'b1);
    probe_rd(2'd1, 32'h82, "full_status");
    step(1);
    bus_wr(2'd2, 32'h1, 4'h1);
    push_byte(8'hE5, 1'b1);
    w = wr_edge;
    probe_rd(2'd1, 32'h83, "push_pop_full");
    wait_to(w + 210);
    probe_rd(2'd1, 32'h14, "five_done");
    probe_pin(2, 1'b0, "five_irq");
    step(1);

    // ignored writes and read-as-zero regs
    bus_wr(2'd1, 32'hFFFF_FFFF, 4'hF);
    bus_wr(2'd2, 32'h3, 4'hE);
    probe_rd(2'd2, 32'h1, "ctrl_be0");
    step(1);
    probe_rd(2'd1, 32'h14, "status_ro");
    step(1);
    probe_rd(2'd0, 32'h0, "data_rd0");
    step(1);
    probe_rd(2'd3, 32'h0, "rsv_rd0");
    step(5);

    n_cmp++;
    if (fq.size() != 0) begin
      n_err++;
      $display("FAIL frames_left: got %0d, required 0",
               fq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
